cmp_tally: RTL and testbench

- Downstream consumer of the 4-bit magnitude comparator.
- Registers the comparator's one-hot result flags (greater / equal / less) and its 2-bit status code, and keeps saturating per-outcome counters.
- Tracks the current run of identical results and raises a streak flag when the run reaches a threshold.
- Detects illegal flag combinations and latches an error.
- Gives the comparator's combinational outputs a clocked, observable history for the control logic above it.

---
 rtl/cmp_tally_pkg.sv | 37 +++
 rtl/cmp_tally_sat_counter.sv | 46 ++++
 rtl/cmp_tally.sv | 195 +++++++++++++++++++
 tb/tb_cmp_tally.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_tally_pkg.sv
// cmp_tally_pkg
// Shared encodings for the comparator tally block: result codes, tally FSM
// states and the comparator status codes (common with the comparator).
package cmp_tally_pkg;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_GT   = 2'b01,
      RES_EQ   = 2'b10,
      RES_LT   = 2'b11
   } res_t;

   typedef enum logic [1:0] {
      TS_IDLE  = 2'b00,
      TS_COUNT = 2'b01,
      TS_HOLD  = 2'b10,
      TS_ERR   = 2'b11
   } tstate_t;

   typedef enum logic [1:0] {
      CMP_ENABLE = 2'b00,
      CMP_PAUSE  = 2'b01,
      CMP_RESET  = 2'b10
   } cmp_state_t;

   // Maps {gt,eq,lt} to a result code; anything that is not one-hot maps to
   // RES_NONE and must be qualified separately.
   function automatic res_t flags_to_res(input logic [2:0] flags);
      case (flags)
         3'b100:  flags_to_res = RES_GT;
         3'b010:  flags_to_res = RES_EQ;
         3'b001:  flags_to_res = RES_LT;
         default: flags_to_res = RES_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cmp_tally_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous reset, soft clear and load-to-one.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clr            : soft clear to zero (over load1/inc)
//   load1          : load the value 1 (start of a new run)
//   inc            : increment, holds at all-ones
//   cnt            : registered count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load1) begin
         cnt_d = W'(1);
      end else if (inc && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/cmp_tally.sv
// cmp_tally
// Clocked tally of a 4-bit magnitude comparator's one-hot result flags:
// saturating per-outcome counters, current run length with a streak flag,
// and a sticky error on illegal flag combinations.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   enable, cmp_state     : sample qualification (enable=1 and status ENABLE)
//   clear                 : soft clear of counters, run, last result and error
//   gt, eq, lt            : comparator result flags
//   gt_cnt/eq_cnt/lt_cnt  : saturating outcome counts
//   run_len, last_res     : current run length and last accepted result
//   streak                : run_len >= RUN_TH
//   err, tstate           : sticky error and FSM state
//
// state    | meaning
// ---------+--------------------------------------------------------
// TS_IDLE  | nothing accepted since reset/clear
// TS_COUNT | last qualified cycle was a sample
// TS_HOLD  | paused (no sample); outputs and run are held
// TS_ERR   | illegal flags seen; frozen until reset or clear
module cmp_tally
   import cmp_tally_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int RUN_TH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             gt,
   input  logic             eq,
   input  logic             lt,
   input  logic [1:0]       cmp_state,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] run_len,
   output logic [1:0]       last_res,
   output logic             streak,
   output logic             err,
   output logic [1:0]       tstate
);

   localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RUN_TH_V = CNT_W'(RUN_TH);

   logic [2:0] flags;
   logic       sample;
   logic       legal;
   logic       illegal;
   logic       acc_ok;
   res_t       res;

   tstate_t state_q, state_d;
   res_t    last_res_q, last_res_d;
   logic    streak_q, streak_d;
   logic    err_q, err_d;

   logic             run_inc;
   logic             run_load1;
   logic [CNT_W-1:0] run_nxt;

   assign flags   = {gt, eq, lt};
   assign sample  = enable && (cmp_state == CMP_ENABLE);
   assign res     = flags_to_res(flags);
   assign legal   = sample && $onehot(flags);
   assign illegal = sample && ($countones(flags) > 1);
   // Once in ERR every sample is ignored; only reset/clear leave it.
   assign acc_ok  = legal && (state_q != TS_ERR);

   assign run_inc   = acc_ok && (res == last_res_q);
   assign run_load1 = acc_ok && (res != last_res_q);

   sat_counter #(.W(CNT_W)) u_gt_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .load1 (1'b0),
      .inc   (acc_ok && (res == RES_GT)),
      .cnt   (gt_cnt)
   );

   sat_counter #(.W(CNT_W)) u_eq_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .load1 (1'b0),
      .inc   (acc_ok && (res == RES_EQ)),
      .cnt   (eq_cnt)
   );

   sat_counter #(.W(CNT_W)) u_lt_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .load1 (1'b0),
      .inc   (acc_ok && (res == RES_LT)),
      .cnt   (lt_cnt)
   );

   sat_counter #(.W(CNT_W)) u_run_len (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .load1 (run_load1),
      .inc   (run_inc),
      .cnt   (run_len)
   );

   // Next run length mirrored here so streak lands on the same edge as run_len.
   always_comb begin
      run_nxt = run_len;
      if (clear) begin
         run_nxt = '0;
      end else if (run_load1) begin
         run_nxt = CNT_W'(1);
      end else if (run_inc && (run_len != RUN_MAX)) begin
         run_nxt = run_len + CNT_W'(1);
      end
   end

   always_comb begin
      last_res_d = last_res_q;
      streak_d   = (run_nxt >= RUN_TH_V);
      err_d      = err_q;
      if (clear) begin
         last_res_d = RES_NONE;
         streak_d   = 1'b0;
         err_d      = 1'b0;
      end else begin
         if (acc_ok) begin
            last_res_d = res;
         end
         if (illegal) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_res_q <= RES_NONE;
         streak_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         last_res_q <= last_res_d;
         streak_q   <= streak_d;
         err_q      <= err_d;
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = TS_IDLE;
      end else begin
         case (state_q)
            TS_IDLE: begin
               if (illegal)     state_d = TS_ERR;
               else if (legal)  state_d = TS_COUNT;
            end
            TS_COUNT: begin
               if (illegal)     state_d = TS_ERR;
               else if (legal)  state_d = TS_COUNT;
               else if (!sample) state_d = TS_HOLD;
            end
            TS_HOLD: begin
               if (illegal)     state_d = TS_ERR;
               else if (legal)  state_d = TS_COUNT;
            end
            default:            state_d = TS_ERR;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      tstate   = state_q;
      err      = err_q;
      streak   = streak_q;
      last_res = last_res_q;
   end

endmodule

// File: tb/tb_cmp_tally.sv
module tb_cmp_tally;

   logic       clk = 1'b0;
   logic       reset, enable, clear, gt, eq, lt;
   logic [1:0] cmp_state;

   logic [7:0] gt_cnt, eq_cnt, lt_cnt, run_len;
   logic [1:0] last_res, tstate;
   logic       streak, err;

   logic [3:0] gt_cnt4, eq_cnt4, lt_cnt4, run_len4;
   logic [1:0] last_res4, tstate4;
   logic       streak4, err4;

   logic [7:0] gt_cnt1, eq_cnt1, lt_cnt1, run_len1;
   logic [1:0] last_res1, tstate1;
   logic       streak1, err1;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   cmp_tally #(.CNT_W(8), .RUN_TH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .gt(gt), .eq(eq), .lt(lt), .cmp_state(cmp_state),
      .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .run_len(run_len),
      .last_res(last_res), .streak(streak), .err(err), .tstate(tstate));

   cmp_tally #(.CNT_W(4), .RUN_TH(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .gt(gt), .eq(eq), .lt(lt), .cmp_state(cmp_state),
      .gt_cnt(gt_cnt4), .eq_cnt(eq_cnt4), .lt_cnt(lt_cnt4), .run_len(run_len4),
      .last_res(last_res4), .streak(streak4), .err(err4), .tstate(tstate4));

   cmp_tally #(.CNT_W(8), .RUN_TH(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .gt(gt), .eq(eq), .lt(lt), .cmp_state(cmp_state),
      .gt_cnt(gt_cnt1), .eq_cnt(eq_cnt1), .lt_cnt(lt_cnt1), .run_len(run_len1),
      .last_res(last_res1), .streak(streak1), .err(err1), .tstate(tstate1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic drive(input logic en, input logic [1:0] cs, input logic [2:0] f);
      enable    = en;
      cmp_state = cs;
      {gt, eq, lt} = f;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0;
      drive(1'b0, 2'b00, 3'b000);
      tick(2);
      chk("rst_gt_cnt", gt_cnt, 0);
      chk("rst_run_len", run_len, 0);
      chk("rst_last_res", last_res, 0);
      chk("rst_tstate", tstate, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;

      // 1: three gt samples
      drive(1'b1, 2'b00, 3'b100);
      tick(1);
      chk("th1_streak_first", streak1, 1);
      chk("th4_streak_first", streak, 0);
      tick(2);
      chk("t1_gt_cnt", gt_cnt, 3);
      chk("t1_run_len", run_len, 3);
      chk("t1_last_res", last_res, 1);
      chk("t1_streak", streak, 0);
      chk("t1_tstate", tstate, 1);

      // 2: fourth gt reaches threshold, then eq breaks the run
      tick(1);
      chk("t2_run_len4", run_len, 4);
      chk("t2_streak_on", streak, 1);
      drive(1'b1, 2'b00, 3'b010);
      tick(1);
      chk("t2_eq_cnt", eq_cnt, 1);
      chk("t2_run_len1", run_len, 1);
      chk("t2_streak_off", streak, 0);
      chk("t2_last_res", last_res, 2);

      // 3: lt, pause, lt; run survives the pause
      drive(1'b1, 2'b00, 3'b001);
      tick(1);
      drive(1'b0, 2'b00, 3'b001);
      tick(1);
      chk("t3_hold", tstate, 2);
      drive(1'b1, 2'b10, 3'b001);
      tick(2);
      chk("t3_hold_cs_reset", tstate, 2);
      drive(1'b0, 2'b00, 3'b000);
      tick(2);
      chk("t3_hold_lt_cnt", lt_cnt, 1);
      drive(1'b1, 2'b00, 3'b001);
      tick(1);
      chk("t3_tstate", tstate, 1);
      chk("t3_lt_cnt", lt_cnt, 2);
      chk("t3_run_len", run_len, 2);

      // flags 000 while sampling: state stays put
      drive(1'b1, 2'b00, 3'b000);
      tick(1);
      chk("t3_zero_flags_state", tstate, 1);
      chk("t3_zero_flags_run", run_len, 2);

      // 4: illegal flags latch error and freeze counters
      drive(1'b1, 2'b00, 3'b110);
      tick(1);
      chk("t4_err", err, 1);
      chk("t4_tstate", tstate, 3);
      drive(1'b1, 2'b00, 3'b100);
      tick(2);
      chk("t4_gt_frozen", gt_cnt, 4);
      chk("t4_run_frozen", run_len, 2);
      chk("t4_err_sticky", err, 1);
      clear = 1'b1;
      drive(1'b0, 2'b00, 3'b000);
      tick(1);
      clear = 1'b0;
      chk("t4_clr_gt", gt_cnt, 0);
      chk("t4_clr_lt", lt_cnt, 0);
      chk("t4_clr_run", run_len, 0);
      chk("t4_clr_last", last_res, 0);
      chk("t4_clr_err", err, 0);
      chk("t4_clr_tstate", tstate, 0);

      // 5: saturation with 20 eq samples
      drive(1'b1, 2'b00, 3'b010);
      tick(20);
      chk("t5_eq_cnt4", eq_cnt4, 15);
      chk("t5_run_len4", run_len4, 15);
      chk("t5_streak4", streak4, 1);
      chk("t5_eq_cnt8", eq_cnt, 20);
      chk("t5_run_len8", run_len, 20);

      // 6: clear with sample drops it; clear beats illegal; reset with clear
      clear = 1'b1;
      drive(1'b1, 2'b00, 3'b100);
      tick(1);
      chk("t6_clr_gt", gt_cnt, 0);
      chk("t6_clr_eq", eq_cnt, 0);
      chk("t6_clr_tstate", tstate, 0);
      clear = 1'b0;
      tick(1);
      chk("t6_gt_after", gt_cnt, 1);
      clear = 1'b1;
      drive(1'b1, 2'b00, 3'b110);
      tick(1);
      chk("t6_clr_vs_illegal_err", err, 0);
      chk("t6_clr_vs_illegal_st", tstate, 0);
      clear = 1'b0;
      drive(1'b1, 2'b00, 3'b001);
      tick(1);
      chk("t6_lt_pre_reset", lt_cnt, 1);
      reset = 1'b1; clear = 1'b1;
      drive(1'b1, 2'b00, 3'b100);
      tick(1);
      chk("t6_rst_gt", gt_cnt, 0);
      chk("t6_rst_lt", lt_cnt, 0);
      chk("t6_rst_run", run_len, 0);
      chk("t6_rst_tstate", tstate, 0);
      reset = 1'b0; clear = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
